// File: rtl/ndp8_4_merge.sv
// ndp8_4_merge: folds 8 egress streams onto 4 lanes.
// Per-input FWFT FIFOs, per-lane round-robin arbiters.
module ndp8_4_merge #(
  parameter int DATA_WIDTH      = 480,
  parameter int CTRL_WIDTH      = 32,
  parameter int NUM_IN_QUEUES   = 8,
  parameter int NUM_OUT_QUEUES  = 4,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_IN_QUEUES-1:0] in_wr,
  input  logic [NUM_IN_QUEUES*CTRL_WIDTH-1:0] in_ctl,
  input  logic [NUM_IN_QUEUES*DATA_WIDTH-1:0] in_data,
  output logic [NUM_IN_QUEUES-1:0] in_rdy,
  output logic [NUM_OUT_QUEUES-1:0] out_wr,
  output logic [NUM_OUT_QUEUES*CTRL_WIDTH-1:0] out_ctl,
  output logic [NUM_OUT_QUEUES*DATA_WIDTH-1:0] out_data,
  output logic [15:0] drop_cnt
);
  localparam int NI    = 8;
  localparam int NO    = 4;
  localparam int PB    = FIFO_DEPTH_BITS;
  localparam int CB    = FIFO_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int WW    = CTRL_WIDTH + DATA_WIDTH;

  logic [WW-1:0] mem [NI][DEPTH];
  logic [PB-1:0] wp [NI];
  logic [PB-1:0] rp [NI];
  logic [CB-1:0] occ [NI];
  logic [WW-1:0] head [NI];
  logic [NI-1:0] req [NO];
  logic [2:0]    ptr [NO];
  logic [2:0]    sel [NO];
  logic [NO-1:0] gnt_any;
  logic [NI-1:0] rd_en;
  logic [NI-1:0] wr_ok;
  logic [NI-1:0] drop;
  logic [3:0]    ndrop;
  logic [16:0]   dsum;

  // Heads, lane requests, accept/drop and ready per input.
  always_comb begin
    for (int j = 0; j < NO; j++) req[j] = '0;
    for (int i = 0; i < NI; i++) begin
      head[i] = mem[i][rp[i]];
      for (int j = 0; j < NO; j++) begin
        if (occ[i] != '0 &&
            head[i][DATA_WIDTH +: 2] == 2'(j))
          req[j][i] = 1'b1;
      end
      wr_ok[i] = in_wr[i] &&
                 (occ[i] != CB'(DEPTH) || rd_en[i]);
      drop[i]  = in_wr[i] &&
                 occ[i] == CB'(DEPTH) && !rd_en[i];
      in_rdy[i] = occ[i] <= CB'(DEPTH - 2);
    end
  end

  // Round-robin scan from ptr; grant pops the FIFO.
  always_comb begin
    logic [2:0] idx;
    rd_en   = '0;
    gnt_any = '0;
    idx     = '0;
    for (int j = 0; j < NO; j++) begin
      sel[j] = '0;
      for (int k = 0; k < NI; k++) begin
        idx = ptr[j] + 3'(k);
        if (!gnt_any[j] && req[j][idx]) begin
          gnt_any[j] = 1'b1;
          sel[j]     = idx;
        end
      end
      if (gnt_any[j]) rd_en[sel[j]] = 1'b1;
    end
  end

  // Total drops this cycle, saturating accumulate.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NI; i++)
      ndrop = ndrop + {3'b0, drop[i]};
    dsum = {1'b0, drop_cnt} + 17'(ndrop);
  end

  // FIFO storage; stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (wr_ok[i])
        mem[i][wp[i]] <= {
          in_ctl[i*CTRL_WIDTH +: CTRL_WIDTH],
          in_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        occ[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (wr_ok[i]) wp[i] <= wp[i] + PB'(1);
        if (rd_en[i]) rp[i] <= rp[i] + PB'(1);
        if (wr_ok[i] && !rd_en[i])
          occ[i] <= occ[i] + CB'(1);
        else if (!wr_ok[i] && rd_en[i])
          occ[i] <= occ[i] - CB'(1);
      end
    end
  end

  // Arbiter pointers, lane output registers, drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NO; j++) ptr[j] <= '0;
      out_wr   <= '0;
      out_ctl  <= '0;
      out_data <= '0;
      drop_cnt <= '0;
    end else begin
      out_wr <= gnt_any;
      for (int j = 0; j < NO; j++) begin
        if (gnt_any[j]) begin
          ptr[j] <= sel[j] + 3'd1;
          out_ctl[j*CTRL_WIDTH +: CTRL_WIDTH] <=
            head[sel[j]][DATA_WIDTH +: CTRL_WIDTH];
          out_data[j*DATA_WIDTH +: DATA_WIDTH] <=
            head[sel[j]][DATA_WIDTH-1:0];
        end
      end
      drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
    end
  end
endmodule
